// File: rtl/avr_fetch.sv
// AVR instruction fetch unit: 2-entry {word, address} prefetch buffer in front of program memory.
// Latency: pm_ack to instr_valid is one cycle; pm_req rises one cycle after reset release.
// Backpressure: instr_ready low holds the head; fetching stops once the buffer plus the in-flight request fill it.
// Option FETCH_TWO_WORD_EN: LDS/STS/JMP/CALL are presented as one transfer with instr2 = second word.
module avr_fetch #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  input  logic            pm_ack,
  input  logic [15:0]     pm_data,
  output logic [15:0]     instr,
  output logic [15:0]     instr2,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_addr
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Buffer storage, head index and occupancy (0..2)
  logic [15:0]     word_q [2];
  logic [PC_W-1:0] addr_q [2];
  logic            rd_q, rd_d;
  logic [1:0]      cnt_q, cnt_d;

  // Request tracking: req_q is the live request held on the bus until acked;
  // stale_q marks a request whose data must be dropped because of a redirect.
  logic            req_q, req_d;
  logic            stale_q, stale_d;
  logic [PC_W-1:0] req_addr_q, req_addr_d;
  logic [PC_W-1:0] fptr_q, fptr_d;

  logic [15:0]     head_w;
  logic            head_two;
  logic            valid;
  logic            ack_acc;
  logic            push;
  logic            xfer;
  logic [1:0]      pop_amt;
  logic            wr_idx;
  logic            still_busy;
  logic            issue;
  logic [PC_W-1:0] fsrc;

  assign head_w = word_q[rd_q];

`ifdef FETCH_TWO_WORD_EN
  logic [15:0] next_w;
  assign next_w   = word_q[~rd_q];
  assign head_two = ((head_w & 16'hFC0F) == 16'h9000) || ((head_w & 16'hFE0C) == 16'h940C);
  // A two-word head is only presentable once its operand word is buffered too
  assign valid    = head_two ? (cnt_q == 2'd2) : (cnt_q != 2'd0);
  assign instr2   = (valid && head_two) ? next_w : 16'h0000;
`else
  assign head_two = 1'b0;
  assign valid    = (cnt_q != 2'd0);
  assign instr2   = 16'h0000;
`endif

  assign instr_valid = valid;
  assign instr       = head_w;
  assign pc          = addr_q[rd_q];
  assign pm_req      = req_q;
  assign pm_addr     = req_addr_q;

  // Next-state for buffer occupancy, request issue and fetch pointer
  always_comb begin
    ack_acc    = pm_ack & req_q;
    push       = ack_acc & ~stale_q & ~redirect;
    xfer       = valid & instr_ready & ~redirect;
    pop_amt    = 2'd0;
    if (xfer) pop_amt = head_two ? 2'd2 : 2'd1;
    // rd + cnt (mod 2): when full, this is the head slot, freed by the same-cycle pop
    wr_idx     = rd_q ^ cnt_q[0];
    rd_d       = rd_q ^ (xfer & ~head_two);
    cnt_d      = redirect ? 2'd0 : (cnt_q - pop_amt + {1'b0, push});

    still_busy = req_q & ~ack_acc;
    fsrc       = redirect ? redirect_addr : fptr_q;
    issue      = ~still_busy & (cnt_d < 2'd2);
    req_d      = still_busy | issue;
    req_addr_d = issue ? fsrc : req_addr_q;
    fptr_d     = issue ? (fsrc + PC_ONE) : fsrc;

    stale_d    = stale_q;
    if (redirect)     stale_d = still_busy;
    else if (ack_acc) stale_d = 1'b0;
  end

  // State registers; reset abandons any in-flight request
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      word_q[0]  <= 16'h0000;
      word_q[1]  <= 16'h0000;
      addr_q[0]  <= RESET_VEC;
      addr_q[1]  <= RESET_VEC;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      req_q      <= 1'b0;
      stale_q    <= 1'b0;
      req_addr_q <= RESET_VEC;
      fptr_q     <= RESET_VEC;
    end else begin
      if (push) begin
        word_q[wr_idx] <= pm_data;
        addr_q[wr_idx] <= req_addr_q;
      end
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      stale_q    <= stale_d;
      req_addr_q <= req_addr_d;
      fptr_q     <= fptr_d;
    end
  end

endmodule

// File: tb/tb_avr_fetch.sv
// Directed bench for avr_fetch: zero-wait memory model, redirect/stale handling,
// backpressure, two-word option, PC wrap on a 4-bit instance, mid-transaction reset.
module tb_avr_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pm_req;
  logic [15:0] pm_addr;
  logic        pm_ack;
  logic [15:0] pm_data;
  logic [15:0] instr, instr2;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic        redirect;
  logic [15:0] redirect_addr;

  logic        ack_en;
  logic        ack_force;
  logic [15:0] mem [256];

  logic        pm_req4;
  logic [3:0]  pm_addr4;
  logic        pm_ack4;
  logic [15:0] pm_data4;
  logic [15:0] instr4, instr2_4;
  logic        valid4;
  logic        ready4;
  logic [3:0]  pc4;
  logic        redirect4;
  logic [3:0]  redirect_addr4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  assign pm_ack   = ack_force | (pm_req & ack_en);
  assign pm_data  = mem[pm_addr[7:0]];
  assign pm_ack4  = pm_req4;
  assign pm_data4 = {12'h500, pm_addr4};

  avr_fetch #(.PC_W(16), .RESET_VEC(16'h0000)) u_dut (
    .CLK(CLK), .RST(RST),
    .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack), .pm_data(pm_data),
    .instr(instr), .instr2(instr2), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .redirect(redirect), .redirect_addr(redirect_addr)
  );

  avr_fetch #(.PC_W(4), .RESET_VEC(4'hE)) u_dut4 (
    .CLK(CLK), .RST(RST),
    .pm_req(pm_req4), .pm_addr(pm_addr4), .pm_ack(pm_ack4), .pm_data(pm_data4),
    .instr(instr4), .instr2(instr2_4), .instr_valid(valid4), .instr_ready(ready4),
    .pc(pc4), .redirect(redirect4), .redirect_addr(redirect_addr4)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    mem[0] = 16'hE0A4;
    for (int i = 1; i < 256; i++) mem[i] = 16'h50A0 + 16'(i);
    mem[8'h80] = 16'h940C;
    mem[8'h81] = 16'h0123;

    RST = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
    ack_en = 1'b1; ack_force = 1'b0;
    ready4 = 1'b1; redirect4 = 1'b0; redirect_addr4 = 4'h0;
    tick; tick;

    // Reset state
    chk("rst_pm_req", pm_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr2", instr2, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pc4", pc4, 4'hE);

    // Release; a stray ack before the first request must be ignored
    RST = 1'b1; ack_force = 1'b1; instr_ready = 1'b1;
    chk("rel_pm_req0", pm_req, 0);
    tick; ack_force = 1'b0;
    chk("first_req", pm_req, 1);
    chk("first_addr", pm_addr, 16'h0000);
    chk("late_ack_ignored", instr_valid, 0);
    chk("first_addr4", pm_addr4, 4'hE);

    tick;
    chk("first_valid", instr_valid, 1);
    chk("first_instr", instr, 16'hE0A4);
    chk("first_pc", pc, 16'h0000);
    chk("addr4_F", pm_addr4, 4'hF);
    chk("pc4_E", pc4, 4'hE);

    // Back-to-back stream
    tick;
    chk("s1_valid", instr_valid, 1);
    chk("s1_instr", instr, 16'h50A1);
    chk("s1_pc", pc, 16'h0001);
    chk("addr4_wrap", pm_addr4, 4'h0);
    chk("pc4_F", pc4, 4'hF);
    tick;
    chk("s2_valid", instr_valid, 1);
    chk("s2_instr", instr, 16'h50A2);
    chk("s2_pc", pc, 16'h0002);

    // Backpressure for 3 cycles: buffer fills to 2, request stops, head stable
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp_no_req", pm_req, 0);
      chk("bp_valid", instr_valid, 1);
      chk("bp_instr", instr, 16'h50A2);
      chk("bp_pc", pc, 16'h0002);
    end
    instr_ready = 1'b1;
    tick;
    chk("bp_rel_instr", instr, 16'h50A3);
    chk("bp_rel_pc", pc, 16'h0003);
    chk("bp_rel_req", pm_req, 1);
    chk("bp_rel_addr", pm_addr, 16'h0004);
    tick;
    chk("bp_next_pc", pc, 16'h0004);
    chk("bp_next_instr", instr, 16'h50A4);
    chk("pre_redir_addr", pm_addr, 16'h0005);

    // Redirect coincident with the ack for 0x0005 and with a transfer
    redirect = 1'b1; redirect_addr = 16'h0040;
    tick; redirect = 1'b0;
    chk("redir_flush_valid", instr_valid, 0);
    chk("redir_addr", pm_addr, 16'h0040);
    chk("redir_req", pm_req, 1);
    tick;
    chk("redir_valid", instr_valid, 1);
    chk("redir_pc", pc, 16'h0040);
    chk("redir_instr", instr, mem[8'h40]);

    // Redirect with a request outstanding: its late ack is discarded
    instr_ready = 1'b0; ack_en = 1'b0;
    tick;
    chk("hold_addr", pm_addr, 16'h0041);
    chk("hold_req", pm_req, 1);
    redirect = 1'b1; redirect_addr = 16'h0080;
    tick; redirect = 1'b0;
    chk("stale_valid", instr_valid, 0);
    chk("stale_addr_held", pm_addr, 16'h0041);
    chk("stale_req_held", pm_req, 1);
    ack_en = 1'b1;
    tick;
    chk("stale_dropped", instr_valid, 0);
    chk("refetch_addr", pm_addr, 16'h0080);
    instr_ready = 1'b1;
    tick;
`ifdef FETCH_TWO_WORD_EN
    chk("tw_wait_second", instr_valid, 0);
    chk("tw_addr81", pm_addr, 16'h0081);
    tick;
    chk("tw_valid", instr_valid, 1);
    chk("tw_instr", instr, 16'h940C);
    chk("tw_instr2", instr2, 16'h0123);
    chk("tw_pc", pc, 16'h0080);
    chk("tw_no_req_full", pm_req, 0);
    tick;
    chk("tw_popped2", instr_valid, 0);
    chk("tw_addr82", pm_addr, 16'h0082);
    tick;
    chk("tw_next_instr", instr, mem[8'h82]);
    chk("tw_next_pc", pc, 16'h0082);
`else
    chk("sw_valid0", instr_valid, 1);
    chk("sw_instr0", instr, 16'h940C);
    chk("sw_instr2_0", instr2, 16'h0000);
    chk("sw_pc0", pc, 16'h0080);
    tick;
    chk("sw_valid1", instr_valid, 1);
    chk("sw_instr1", instr, 16'h0123);
    chk("sw_instr2_1", instr2, 16'h0000);
    chk("sw_pc1", pc, 16'h0081);
    tick;
    chk("sw_next_instr", instr, mem[8'h82]);
    chk("sw_next_pc", pc, 16'h0082);
`endif

    // Reset asserted with a request outstanding
    ack_en = 1'b0;
    tick;
    chk("mid_req_pending", pm_req, 1);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_req", pm_req, 0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_instr", instr, 16'h0000);
    ack_en = 1'b1;
    tick;
    RST = 1'b1;
    chk("re_rel_req0", pm_req, 0);
    tick;
    chk("re_req", pm_req, 1);
    chk("re_addr", pm_addr, 16'h0000);
    tick;
    chk("re_valid", instr_valid, 1);
    chk("re_instr", instr, 16'hE0A4);
    chk("re_pc", pc, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
